// File: rtl/dx_skid_latch.sv
// dx_skid_latch: decode-to-execute 2-entry skid buffer with flush and saturating stall counter
// MAIN drives the execute side; SKID absorbs the beat accepted while execute stalls.
module dx_skid_latch #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 17,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_insn,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_insn,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [4:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_shamt,
    output logic [4:0]        out_aluop,
    output logic [IMM_W-1:0]  out_imm,
    output logic [26:0]       out_target,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] insn;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
    } beat_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state;
    beat_t  main_q, skid_q, in_beat;
    logic   accept, drain;
    assign in_beat   = {in_pc, in_insn, in_rs_data, in_rt_data};
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign {out_pc, out_insn, out_rs_data, out_rt_data} = main_q;
    assign out_opcode = out_insn[31:27];
    assign out_rd     = out_insn[26:22];
    assign out_rs     = out_insn[21:17];
    assign out_rt     = out_insn[16:12];
    assign out_shamt  = out_insn[11:7];
    assign out_aluop  = out_insn[6:2];
    assign out_imm    = out_insn[IMM_W-1:0];
    assign out_target = out_insn[26:0];
    // in_ready is kept as its own flop so execute stalls never reach decode combinationally
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush) begin
                state    <= EMPTY;
                main_q   <= '0;
                skid_q   <= '0;
                in_ready <= 1'b1;
            end else begin
                case (state)
                    EMPTY: if (accept) begin
                        main_q <= in_beat;
                        state  <= ONE;
                    end
                    ONE: if (accept && !drain) begin
                        skid_q   <= in_beat;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (drain && !accept) begin
                        main_q <= '0;
                        state  <= EMPTY;
                    end else if (accept && drain) begin
                        main_q <= in_beat;
                    end
                    FULL: if (drain) begin
                        main_q   <= skid_q;
                        skid_q   <= '0;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dx_skid_latch.sv
// tb_dx_skid_latch: scenario tasks plus a negedge scoreboard that tracks queued beats and stall count
module tb_dx_skid_latch;
    localparam int CW = 4;
    localparam logic [CW-1:0] SAT = '1;
    logic          clock = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0]   in_pc = 0, in_insn = 0, in_rs_data = 0, in_rt_data = 0;
    logic          in_ready, out_valid;
    logic [31:0]   out_pc, out_insn, out_rs_data, out_rt_data;
    logic [4:0]    out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop;
    logic [16:0]   out_imm;
    logic [26:0]   out_target;
    logic [CW-1:0] stall_cnt;
    int n_cmp = 0, n_fail = 0, n_drained = 0, cycles = 0;
    logic [127:0]  q[$];
    logic [127:0]  h;
    logic [31:0]   hi;
    logic [CW-1:0] m_cnt = '0;
    bit            rdy;

    always #5 clock = ~clock;

    dx_skid_latch #(.DATA_W(32), .IMM_W(17), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_insn(in_insn), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_shamt(out_shamt), .out_aluop(out_aluop), .out_imm(out_imm), .out_target(out_target),
        .stall_cnt(stall_cnt)
    );

    // Scoreboard: beats pushed on accept, compared while at the head, popped on drain
    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            m_cnt = '0;
        end else begin
            rdy = q.size() < 2;
            h = (q.size() > 0) ? q[0] : '0;
            hi = h[95:64];
            n_cmp++; if (in_ready !== rdy) begin n_fail++; $display("FAIL sb_in_ready: got %b want %b", in_ready, rdy); end
            n_cmp++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL sb_out_valid: got %b want %b", out_valid, q.size() > 0); end
            n_cmp++; if ({out_pc, out_insn, out_rs_data, out_rt_data} !== h) begin n_fail++; $display("FAIL sb_payload: got %h want %h", {out_pc, out_insn, out_rs_data, out_rt_data}, h); end
            n_cmp++; if ({out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop, out_imm, out_target} !== {hi[31:27], hi[26:22], hi[21:17], hi[16:12], hi[11:7], hi[6:2], hi[16:0], hi[26:0]}) begin
                n_fail++; $display("FAIL sb_fields: got %h want %h", {out_opcode, out_rd, out_rs, out_rt, out_shamt, out_aluop, out_imm, out_target}, {hi[31:27], hi[26:22], hi[21:17], hi[16:12], hi[11:7], hi[6:2], hi[16:0], hi[26:0]});
            end
            n_cmp++; if (stall_cnt !== m_cnt) begin n_fail++; $display("FAIL sb_stall_cnt: got %0d want %0d", stall_cnt, m_cnt); end
            if (q.size() > 0 && !out_ready && m_cnt != SAT) m_cnt = m_cnt + 1'b1;
            if (flush) q.delete();
            else begin
                if (q.size() > 0 && out_ready) begin void'(q.pop_front()); n_drained++; end
                if (in_valid && rdy) q.push_back({in_pc, in_insn, in_rs_data, in_rt_data});
            end
        end
    end

    task automatic tick;
        @(posedge clock); #1;
        cycles++;
    endtask

    task automatic do_reset;
        reset_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        repeat (2) tick;
        reset_n = 1;
        tick;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] insn);
        bit ok;
        int b = 0;
        in_valid = 1; in_pc = pc; in_insn = insn; in_rs_data = pc ^ 32'hA5A5_0000; in_rt_data = ~pc;
        do begin ok = in_ready; tick; b++; end while (!ok && b < 50);
        in_valid = 0;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL send_timeout: got ready=%b want 1 within 50 cycles", ok); end
    endtask

    task automatic drain_all;
        int b = 0;
        out_ready = 1;
        while (out_valid && b < 50) begin tick; b++; end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_timeout: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if ({out_pc, out_insn} !== 64'h0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", {out_pc, out_insn}); end
    endtask

    task automatic test_single_beat;
        do_reset;
        out_ready = 1;
        send(32'h10, 32'h2A45_A00C);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_pc !== 32'h10) begin n_fail++; $display("FAIL single_pc: got %h want 10", out_pc); end
        n_cmp++; if ({out_opcode, out_rd, out_rs, out_rt} !== {5'd5, 5'd9, 5'h02, 5'h1A}) begin n_fail++; $display("FAIL single_regs: got %h want %h", {out_opcode, out_rd, out_rs, out_rt}, {5'd5, 5'd9, 5'h02, 5'h1A}); end
        n_cmp++; if ({out_shamt, out_aluop} !== {5'd0, 5'd3}) begin n_fail++; $display("FAIL single_shamt_aluop: got %h want %h", {out_shamt, out_aluop}, {5'd0, 5'd3}); end
        n_cmp++; if (out_imm !== 17'h1A00C) begin n_fail++; $display("FAIL single_imm: got %h want 1a00c", out_imm); end
        n_cmp++; if (out_target !== 27'h245_A00C) begin n_fail++; $display("FAIL single_target: got %h want 245a00c", out_target); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid: got %b want 0", out_valid); end
        n_cmp++; if ({out_pc, out_insn, out_imm, out_target} !== '0) begin n_fail++; $display("FAIL single_after_zero: got %h want 0", {out_pc, out_insn, out_imm, out_target}); end
    endtask

    task automatic test_back_pressure;
        int d0;
        do_reset;
        d0 = n_drained;
        out_ready = 0;
        send(32'h0, 32'h1111_0001);
        send(32'h4, 32'h2222_0002);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        in_valid = 1; in_pc = 32'h8; in_insn = 32'h3333_0003;
        repeat (3) tick;
        n_cmp++; if (stall_cnt !== CW'(4)) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d want 4", stall_cnt); end
        n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 0", out_pc); end
        out_ready = 1;
        send(32'h8, 32'h3333_0003);
        drain_all;
        n_cmp++; if (n_drained - d0 !== 3) begin n_fail++; $display("FAIL bp_drained: got %0d want 3", n_drained - d0); end
        n_cmp++; if (stall_cnt !== CW'(4)) begin n_fail++; $display("FAIL bp_stall_hold: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_back_to_back;
        int d0, c0;
        do_reset;
        d0 = n_drained;
        out_ready = 1;
        c0 = cycles;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1 at beat %0d", in_ready, i); end
            send(32'h100 + 32'(i * 4), {8'(i), 24'hC0FFEE});
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1 at beat %0d", out_valid, i); end
        end
        n_cmp++; if (cycles - c0 !== 8) begin n_fail++; $display("FAIL b2b_throughput: got %0d cycles want 8", cycles - c0); end
        drain_all;
        n_cmp++; if (n_drained - d0 !== 8) begin n_fail++; $display("FAIL b2b_drained: got %0d want 8", n_drained - d0); end
    endtask

    task automatic test_flush;
        do_reset;
        out_ready = 0;
        send(32'h20, 32'h4444_0004);
        send(32'h24, 32'h5555_0005);
        in_valid = 1; in_pc = 32'hDEAD; in_insn = 32'hFFFF_FFFF;
        flush = 1;
        tick;
        flush = 0; in_valid = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        n_cmp++; if ({out_pc, out_insn, out_rs_data, out_rt_data, out_imm} !== '0) begin n_fail++; $display("FAIL flush_zero: got %h want 0", {out_pc, out_insn, out_rs_data, out_rt_data, out_imm}); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost: got %b want 0 (pc %h)", out_valid, out_pc); end
        end
    endtask

    task automatic test_saturation;
        do_reset;
        out_ready = 0;
        send(32'h40, 32'h6666_0006);
        repeat (20) tick;
        n_cmp++; if (stall_cnt !== SAT) begin n_fail++; $display("FAIL sat_value: got %0d want %0d", stall_cnt, SAT); end
        flush = 1;
        tick;
        flush = 0;
        tick;
        n_cmp++; if (stall_cnt !== SAT) begin n_fail++; $display("FAIL sat_after_flush: got %0d want %0d", stall_cnt, SAT); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_flush_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset;
        do_reset;
        out_ready = 0;
        send(32'h80, 32'h7777_0007);
        send(32'h84, 32'h8888_0008);
        tick;
        n_cmp++; if ({out_valid, in_ready} !== 2'b10 || stall_cnt === '0) begin n_fail++; $display("FAIL ar_precond: got valid/ready %b%b cnt %0d want 10 cnt>0", out_valid, in_ready, stall_cnt); end
        #2 reset_n = 0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL ar_stall_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if ({out_pc, out_insn} !== 64'h0) begin n_fail++; $display("FAIL ar_payload: got %h want 0", {out_pc, out_insn}); end
        repeat (2) tick;
        reset_n = 1;
        tick;
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL ar_release: got ready/valid %b%b want 10", in_ready, out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_beat;
        test_back_pressure;
        test_back_to_back;
        test_flush;
        test_saturation;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
